// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings and defaults for the memory-access stage
package mem_stage_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int TIMEOUT_DEF = 16;
    typedef enum logic {IDLE, WAIT} state_e;
endpackage

// File: rtl/ls_align.sv
// ls_align: byte-lane enables, store data replication and load extract/extend
module ls_align import mem_stage_pkg::*; (
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    // size 11 falls through every byte/half test and behaves as a word
    always_comb begin
        byte_lane   = rdata_i[8*addr_lo_i +: 8];
        half_lane   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o        = size_i == SZ_BYTE ? 4'b0001 << addr_lo_i :
                      size_i == SZ_HALF ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o     = size_i == SZ_BYTE ? {4{store_data_i[7:0]}} :
                      size_i == SZ_HALF ? {2{store_data_i[15:0]}} : store_data_i;
        load_data_o = size_i == SZ_BYTE ? {{24{~unsigned_i & byte_lane[7]}}, byte_lane} :
                      size_i == SZ_HALF ? {{16{~unsigned_i & half_lane[15]}}, half_lane} : rdata_i;
        misalign_o  = size_i == SZ_BYTE ? 1'b0 :
                      size_i == SZ_HALF ? addr_lo_i[0] : |addr_lo_i;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: drives the valid/ack data bus for loads/stores and feeds MEM/WB
module mem_access_stage import mem_stage_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic [31:0] alu_c_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  reg_rd_in,
    input  logic        regw_in,
    input  logic        mem2r_in,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        stall_out,
    output logic [31:0] alu_c_out,
    output logic [31:0] dm_data_out,
    output logic [4:0]  reg_rd_out,
    output logic        regw_out,
    output logic        mem2r_out,
    output logic        misalign_exc,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT);
    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, sd_q;
    logic [1:0]     size_q;
    logic           uns_q, we_q;
    logic           access, in_wait, mis, misalign, req, timeout, stall, done, capture;
    logic [31:0]    sel_addr, wdata, load_data;
    logic [3:0]     be;
    assign access   = mem_read_in | mem_write_in;
    assign in_wait  = state_q == WAIT;
    assign sel_addr = in_wait ? addr_q : alu_c_in;
    ls_align u_align (
        .addr_lo_i    (sel_addr[1:0]),
        .size_i       (in_wait ? size_q : mem_size_in),
        .unsigned_i   (in_wait ? uns_q : mem_unsigned_in),
        .store_data_i (in_wait ? sd_q : store_data_in),
        .rdata_i      (dbus_rdata),
        .be_o         (be),
        .wdata_o      (wdata),
        .load_data_o  (load_data),
        .misalign_o   (mis)
    );
    assign misalign = ~in_wait & access & mis;
    assign capture  = ~in_wait & access & ~mis;
    assign req      = in_wait | capture;
    assign timeout  = in_wait & ~dbus_ack & (cnt_q == CW'(TIMEOUT - 1));
    assign stall    = req & ~dbus_ack & ~timeout;
    assign done     = req & dbus_ack;
    // state, timeout counter and the request holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            sd_q    <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q <= alu_c_in;
                sd_q   <= store_data_in;
                size_q <= mem_size_in;
                uns_q  <= mem_unsigned_in;
                we_q   <= mem_write_in;
            end
        end
    end
    // enter WAIT on an unacknowledged request, leave on ack or timeout
    always_comb begin
        state_d = in_wait ? ((dbus_ack | timeout) ? IDLE : WAIT) : ((capture & ~dbus_ack) ? WAIT : IDLE);
        cnt_d   = in_wait ? ((dbus_ack | timeout) ? '0 : cnt_q + CW'(1)) : ((capture & ~dbus_ack) ? CW'(1) : '0);
    end
    // bus and MEM/WB outputs; reset and stall cycles present a bubble
    always_comb begin
        dbus_req     = ~rst & req;
        dbus_we      = ~rst & req & (in_wait ? we_q : mem_write_in);
        dbus_addr    = rst ? '0 : {sel_addr[31:2], 2'b00};
        dbus_be      = (rst | ~req) ? '0 : be;
        dbus_wdata   = rst ? '0 : wdata;
        stall_out    = ~rst & stall;
        alu_c_out    = alu_c_in;
        dm_data_out  = (done & ~(in_wait ? we_q : mem_write_in)) ? load_data : '0;
        reg_rd_out   = reg_rd_in;
        regw_out     = ~rst & regw_in & ~stall & ~timeout & ~misalign;
        mem2r_out    = ~rst & mem2r_in & ~stall;
        misalign_exc = ~rst & misalign;
        bus_err      = ~rst & timeout;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for the memory-access stage
module tb_mem_access_stage;
    localparam int TO = 16;
    logic        clk = 1'b0, rst;
    logic        mem_read_in, mem_write_in, mem_unsigned_in, regw_in, mem2r_in;
    logic [1:0]  mem_size_in;
    logic [31:0] alu_c_in, store_data_in, dbus_rdata;
    logic [4:0]  reg_rd_in;
    logic        dbus_req, dbus_we, dbus_ack, stall_out, regw_out, mem2r_out, misalign_exc, bus_err;
    logic [31:0] dbus_addr, dbus_wdata, alu_c_out, dm_data_out;
    logic [3:0]  dbus_be;
    logic [4:0]  reg_rd_out;
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic [31:0] addr, wdata, dm;
        logic [3:0]  be;
        logic        we, regw, mem2r, berr;
        logic [4:0]  rd;
        int          stalls;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_size_in(mem_size_in),
        .mem_unsigned_in(mem_unsigned_in), .alu_c_in(alu_c_in), .store_data_in(store_data_in),
        .reg_rd_in(reg_rd_in), .regw_in(regw_in), .mem2r_in(mem2r_in),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .stall_out(stall_out), .alu_c_out(alu_c_out), .dm_data_out(dm_data_out),
        .reg_rd_out(reg_rd_out), .regw_out(regw_out), .mem2r_out(mem2r_out),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rdreg,
                         input logic regw, input logic m2r);
        mem_read_in = rd; mem_write_in = wr; mem_size_in = size; mem_unsigned_in = uns;
        alu_c_in = addr; store_data_in = sd; reg_rd_in = rdreg; regw_in = regw; mem2r_in = m2r;
    endtask

    task automatic mem_op(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                          input int ack_at, input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_dm);
        exp_t e, got;
        int stalls = 0;
        bit fin = 0;
        e = '{addr: e_addr, wdata: e_wdata, dm: e_dm, be: e_be, we: wr, regw: rd, mem2r: rd,
              berr: ack_at < 0, rd: 5'd9, stalls: (ack_at < 0) ? TO - 1 : ack_at};
        sb_q.push_back(e);
        drive(rd, wr, size, uns, addr, sd, 5'd9, rd, rd);
        dbus_rdata = rdata;
        for (int c = 0; c < 40 && !fin; c++) begin
            dbus_ack = (c == ack_at);
            @(negedge clk);
            if (stall_out) begin
                stalls++;
                check("regw_stall", regw_out, 0);
                check("addr_hold", dbus_addr, e_addr);
            end else if (bus_err || (dbus_req && dbus_ack)) begin
                got = sb_q.pop_front();
                fin = 1;
                check("stalls", stalls, got.stalls);
                check("bus_err", bus_err, got.berr);
                check("regw", regw_out, got.berr ? 1'b0 : got.regw);
                if (!got.berr) begin
                    check("addr", dbus_addr, got.addr);
                    check("be", dbus_be, got.be);
                    check("wdata", dbus_wdata, got.wdata);
                    check("we", dbus_we, got.we);
                    check("dm", dm_data_out, got.dm);
                    check("rd", reg_rd_out, got.rd);
                    check("mem2r", mem2r_out, got.mem2r);
                end
            end
            @(posedge clk); #1;
        end
        check("op_done", fin, 1);
        if (!fin) void'(sb_q.pop_front());
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        dbus_ack = 0;
    endtask

    initial begin
        rst = 1; dbus_ack = 0; dbus_rdata = 0;
        drive(1, 0, 2'b10, 0, 32'h40, 0, 5'd3, 1, 1);
        @(negedge clk);
        check("rst_req", dbus_req, 0);
        check("rst_stall", stall_out, 0);
        check("rst_regw", regw_out, 0);
        check("rst_mem2r", mem2r_out, 0);
        check("rst_be", dbus_be, 0);
        @(posedge clk); #1;
        rst = 0;
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        mem_op(0, 1, 2'b10, 0, 32'h104, 32'hDEADBEEF, 0, 0, 32'h104, 4'b1111, 32'hDEADBEEF, 0);
        mem_op(1, 0, 2'b00, 0, 32'h203, 0, 32'h80123456, 3, 32'h200, 4'b1000, 0, 32'hFFFFFF80);
        mem_op(1, 0, 2'b00, 1, 32'h203, 0, 32'h80123456, 3, 32'h200, 4'b1000, 0, 32'h00000080);
        mem_op(0, 1, 2'b01, 0, 32'h12, 32'h0000ABCD, 0, 1, 32'h10, 4'b1100, 32'hABCDABCD, 0);
        mem_op(1, 0, 2'b01, 0, 32'h12, 0, 32'h80017FFF, 0, 32'h10, 4'b1100, 0, 32'hFFFF8001);
        mem_op(1, 0, 2'b01, 1, 32'h10, 0, 32'h80017FFF, 2, 32'h10, 4'b0011, 0, 32'h00007FFF);
        mem_op(0, 1, 2'b00, 0, 32'h101, 32'h11223344, 0, 0, 32'h100, 4'b0010, 32'h44444444, 0);
        mem_op(1, 0, 2'b11, 0, 32'h8, 0, 32'h12345678, 0, 32'h8, 4'b1111, 0, 32'h12345678);

        drive(1, 0, 2'b01, 0, 32'h11, 0, 5'd4, 1, 1);
        @(negedge clk);
        check("mis_exc", misalign_exc, 1);
        check("mis_req", dbus_req, 0);
        check("mis_regw", regw_out, 0);
        check("mis_stall", stall_out, 0);
        @(posedge clk); #1;

        mem_op(1, 0, 2'b10, 0, 32'h300, 0, 32'h0BADF00D, -1, 32'h300, 4'b1111, 0, 0);
        @(negedge clk);
        check("post_to_req", dbus_req, 0);
        check("post_to_err", bus_err, 0);
        @(posedge clk); #1;
        mem_op(1, 0, 2'b10, 0, 32'h304, 0, 32'hCAFEF00D, TO - 1, 32'h304, 4'b1111, 0, 32'hCAFEF00D);

        drive(1, 0, 2'b10, 0, 32'h40, 0, 5'd9, 1, 1);
        @(negedge clk);
        check("rw_stall0", stall_out, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rw_stall1", stall_out, 1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("rw_rst_req", dbus_req, 0);
        check("rw_rst_stall", stall_out, 0);
        @(posedge clk); #1;
        rst = 0;
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rw_after_req", dbus_req, 0);
        check("rw_after_stall", stall_out, 0);
        @(posedge clk); #1;
        mem_op(1, 0, 2'b10, 0, 32'h44, 0, 32'h5A5A1234, 0, 32'h44, 4'b1111, 0, 32'h5A5A1234);

        drive(0, 0, 2'b10, 0, 32'h55, 32'h99, 5'd7, 1, 0);
        @(negedge clk);
        check("add_alu", alu_c_out, 32'h55);
        check("add_rd", reg_rd_out, 7);
        check("add_regw", regw_out, 1);
        check("add_mem2r", mem2r_out, 0);
        check("add_req", dbus_req, 0);
        check("add_dm", dm_data_out, 0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
